// File: rtl/psum_deskew_writer.sv
// Re-aligns skewed partial sums from the bottom PE row, saturates each to a byte,
// and writes one packed row per cycle to GBUFF_OUT at base_addr + row.
module psum_deskew_writer #(
  parameter int ARRAY_SIZE = 5,
  parameter int ACC_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [3:0]                       m,
  input  logic [3:0]                       n,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ARRAY_SIZE-1:0]            psum_valid,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  psum_data,
  output logic                             gbuf_wen,
  output logic [ADDR_WIDTH-1:0]            gbuf_waddr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] gbuf_wdata,
  output logic                             busy,
  output logic                             done,
  output logic                             ovf_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_e;

  state_e                          state_q, state_d;
  logic [3:0]                      m_q;
  logic [3:0]                      row_q;
  logic [ADDR_WIDTH-1:0]           base_q;
  logic [ARRAY_SIZE-1:0]           active_q, active_d;
  logic                            wen_q;
  logic [ADDR_WIDTH-1:0]           waddr_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wdata_q, packed_d;
  logic                            ovf_q;
  logic                            start_ok;
  logic                            collecting;
  logic                            row_ready;

  // Per-column de-skew FIFOs hold already-saturated bytes.
  logic [DATA_WIDTH-1:0] mem_q    [ARRAY_SIZE][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [ARRAY_SIZE];
  logic [PTR_W-1:0]      rd_ptr_q [ARRAY_SIZE];
  logic [CNT_W-1:0]      cnt_q    [ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] sat_byte [ARRAY_SIZE];

  logic [ARRAY_SIZE-1:0] push, pop, full, push_ok, ovf_hit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (m == 4'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        // row_q already counts the row whose write is on the bus this cycle.
        if (wen_q && (row_q == m_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Column j is active when j < n; this also clamps n to ARRAY_SIZE.
  always_comb begin
    active_d = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      active_d[j] = (n > 4'(j));
    end
  end

  assign collecting = (state_q == S_COLLECT);

  always_comb begin
    row_ready = collecting && (row_q != m_q);
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      if (active_q[j] && (cnt_q[j] == '0)) row_ready = 1'b0;
    end
  end

  always_comb begin
    push     = '0;
    pop      = '0;
    full     = '0;
    push_ok  = '0;
    ovf_hit  = '0;
    packed_d = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      sat_byte[j] = (psum_data[j*ACC_WIDTH +: ACC_WIDTH] > SAT_MAX)
                  ? {DATA_WIDTH{1'b1}}
                  : psum_data[j*ACC_WIDTH +: DATA_WIDTH];
      push[j]    = collecting && psum_valid[j] && active_q[j];
      pop[j]     = row_ready && active_q[j];
      full[j]    = (cnt_q[j] == CNT_FULL);
      push_ok[j] = push[j] && (!full[j] || pop[j]);
      ovf_hit[j] = push[j] && full[j] && !pop[j];
      packed_d[(ARRAY_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] =
        active_q[j] ? mem_q[j][rd_ptr_q[j]] : '0;
    end
  end

  // NOTE: FIFO storage carries no reset; validity is tracked by the reset pointers and counts.
  always_ff @(posedge clk) begin
    for (int j = 0; j < ARRAY_SIZE; j++) begin
      if (push_ok[j]) mem_q[j][wr_ptr_q[j]] <= sat_byte[j];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      row_q    <= '0;
      base_q   <= '0;
      active_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ovf_q    <= 1'b0;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        cnt_q[j]    <= '0;
      end
    end else begin
      state_q <= state_d;
      wen_q   <= row_ready;

      if (start_ok) begin
        m_q      <= m;
        base_q   <= base_addr;
        active_q <= active_d;
        row_q    <= '0;
        ovf_q    <= 1'b0;
      end else if (|ovf_hit) begin
        ovf_q <= 1'b1;
      end

      // Address/data only move on a write, so they hold while gbuf_wen is low.
      if (row_ready) begin
        waddr_q <= base_q + ADDR_WIDTH'(row_q);
        wdata_q <= packed_d;
        row_q   <= row_q + 4'd1;
      end

      for (int j = 0; j < ARRAY_SIZE; j++) begin
        if (state_q == S_DONE) begin
          wr_ptr_q[j] <= '0;
          rd_ptr_q[j] <= '0;
          cnt_q[j]    <= '0;
        end else begin
          if (push_ok[j]) wr_ptr_q[j] <= next_ptr(wr_ptr_q[j]);
          if (pop[j])     rd_ptr_q[j] <= next_ptr(rd_ptr_q[j]);
          if (push_ok[j] && !pop[j])      cnt_q[j] <= cnt_q[j] + 1'b1;
          else if (!push_ok[j] && pop[j]) cnt_q[j] <= cnt_q[j] - 1'b1;
        end
      end
    end
  end

  assign gbuf_wen   = wen_q;
  assign gbuf_waddr = waddr_q;
  assign gbuf_wdata = wdata_q;
  assign busy       = collecting;
  assign done       = (state_q == S_DONE);
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_psum_deskew_writer.sv
// Directed bench for psum_deskew_writer: expected row writes are queued as stimulus is
// driven and popped by a write monitor; job-level checks follow each step.
module tb_psum_deskew_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  m, n;
  logic [7:0]  base_addr;
  logic [4:0]  psum_valid;
  logic [79:0] psum_data;
  logic        gbuf_wen;
  logic [7:0]  gbuf_waddr;
  logic [39:0] gbuf_wdata;
  logic        busy, done, ovf_err;

  psum_deskew_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m          (m),
    .n          (n),
    .base_addr  (base_addr),
    .psum_valid (psum_valid),
    .psum_data  (psum_data),
    .gbuf_wen   (gbuf_wen),
    .gbuf_waddr (gbuf_waddr),
    .gbuf_wdata (gbuf_wdata),
    .busy       (busy),
    .done       (done),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [39:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          cyc = 0, n_writes = 0, done_count = 0;
  int          last_wen_cyc = 0, done_cyc = 0;
  logic [7:0]  last_waddr;
  logic [39:0] last_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (gbuf_wen) begin
      wr_t e;
      n_writes++;
      last_wen_cyc = cyc;
      last_waddr   = gbuf_waddr;
      last_wdata   = gbuf_wdata;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("waddr", 64'(gbuf_waddr), 64'(e.addr));
        check("wdata", 64'(gbuf_wdata), 64'(e.data));
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [3:0] mm, input logic [3:0] nn, input logic [7:0] base);
    start     = 1'b1;
    m         = mm;
    n         = nn;
    base_addr = base;
    step();
    start = 1'b0;
  endtask

  function automatic logic [39:0] pack_row(input int v[5]);
    logic [39:0] w;
    w = '0;
    for (int j = 0; j < 5; j++) begin
      w[(4-j)*8 +: 8] = (v[j] > 255) ? 8'hFF : 8'(v[j]);
    end
    return w;
  endfunction

  function automatic wr_t mk(input logic [7:0] a, input logic [39:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  int A[5][5], B[5][5], C[5][5];
  int row_v[5];
  int dc0, nw0;

  initial begin
    A = '{'{1,0,0,0,0}, '{0,1,1,0,0}, '{1,1,1,1,1}, '{0,0,0,1,1}, '{1,1,1,0,0}};
    B = '{'{1,1,1,1,1}, '{1,1,0,1,1}, '{0,1,1,1,1}, '{1,0,1,0,1}, '{0,1,0,1,0}};
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        C[i][j] = 0;
        for (int k = 0; k < 5; k++) C[i][j] += A[i][k] * B[k][j];
      end

    rst = 1'b0; start = 1'b0; m = '0; n = '0; base_addr = '0;
    psum_valid = '0; psum_data = '0;
    step(); step();
    check("reset_wen",   64'(gbuf_wen),   64'd0);
    check("reset_waddr", 64'(gbuf_waddr), 64'd0);
    check("reset_wdata", 64'(gbuf_wdata), 64'd0);
    check("reset_busy",  64'(busy),       64'd0);
    check("reset_done",  64'(done),       64'd0);
    check("reset_ovf",   64'(ovf_err),    64'd0);
    rst = 1'b1;
    step();

    // 1: 5x5 matrix product streamed with j-cycle column skew
    start_job(4'd5, 4'd5, 8'h00);
    check("t1_busy", 64'(busy), 64'd1);
    for (int t = 0; t < 9; t++) begin
      psum_valid = '0;
      psum_data  = '0;
      for (int j = 0; j < 5; j++) begin
        if (t - j >= 0 && t - j < 5) begin
          psum_valid[j] = 1'b1;
          psum_data[j*16 +: 16] = 16'(C[t-j][j]);
        end
      end
      if (t < 5) begin
        for (int j = 0; j < 5; j++) row_v[j] = C[t][j];
        exp_q.push_back(mk(8'(t), pack_row(row_v)));
      end
      step();
    end
    psum_valid = '0;
    repeat (8) step();
    check("t1_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t1_writes",        64'(n_writes),     64'd5);
    check("t1_row4_addr",     64'(last_waddr),   64'h04);
    check("t1_row4_data",     64'(last_wdata),   64'h0203020303);
    check("t1_done_count",    64'(done_count),   64'd1);
    check("t1_done_timing",   64'(done_cyc),     64'(last_wen_cyc + 1));
    check("t1_busy_end",      64'(busy),         64'd0);

    // 2: n=3 masks columns 3-4
    dc0 = done_count;
    start_job(4'd2, 4'd3, 8'h10);
    for (int r = 0; r < 2; r++) begin
      psum_valid = 5'b11111;
      psum_data  = {5{16'h0001}};
      exp_q.push_back(mk(8'h10 + 8'(r), 40'h0101010000));
      step();
    end
    psum_valid = '0;
    repeat (6) step();
    check("t2_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t2_done_count",    64'(done_count),   64'(dc0 + 1));

    // 3: saturation, one-cycle write latency, one row per cycle
    dc0 = done_count;
    start_job(4'd3, 4'd1, 8'h20);
    psum_valid = 5'b00001;
    psum_data  = 80'(16'h0123);
    exp_q.push_back(mk(8'h20, 40'hFF00000000));
    step();
    check("t3_no_write_yet", 64'(gbuf_wen), 64'd0);
    psum_data = 80'(16'h00FF);
    exp_q.push_back(mk(8'h21, 40'hFF00000000));
    step();
    check("t3_latency_wen", 64'(gbuf_wen), 64'd1);
    psum_data = 80'(16'h0000);
    exp_q.push_back(mk(8'h22, 40'h0000000000));
    step();
    check("t3_tput_wen1", 64'(gbuf_wen), 64'd1);
    psum_valid = '0;
    step();
    check("t3_tput_wen2", 64'(gbuf_wen), 64'd1);
    step();
    check("t3_wen_low",  64'(gbuf_wen),   64'd0);
    check("t3_hold_addr", 64'(gbuf_waddr), 64'h22);
    check("t3_done",     64'(done),       64'd1);
    step();
    check("t3_done_pulse", 64'(done), 64'd0);
    check("t3_done_count", 64'(done_count), 64'(dc0 + 1));

    // 4: column 0 overflows its FIFO; 9th value is dropped
    dc0 = done_count;
    nw0 = n_writes;
    start_job(4'd1, 4'd5, 8'h30);
    for (int k = 1; k <= 9; k++) begin
      psum_valid = 5'b00001;
      psum_data  = 80'(16'(k));
      step();
      if (k == 8) check("t4_no_ovf_at_full", 64'(ovf_err), 64'd0);
    end
    psum_valid = '0;
    check("t4_ovf_set",   64'(ovf_err),  64'd1);
    check("t4_no_writes", 64'(n_writes), 64'(nw0));
    psum_valid = 5'b11110;
    psum_data  = {{4{16'h0007}}, 16'h0000};
    exp_q.push_back(mk(8'h30, 40'h0107070707));
    step();
    psum_valid = '0;
    repeat (5) step();
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t4_done_count",    64'(done_count),   64'(dc0 + 1));
    check("t4_ovf_sticky",    64'(ovf_err),      64'd1);

    // 5: m=0 job, then start while busy is ignored
    nw0 = n_writes;
    dc0 = done_count;
    start_job(4'd0, 4'd5, 8'h00);
    check("t5_ovf_cleared", 64'(ovf_err), 64'd0);
    check("t5_m0_done",     64'(done),    64'd1);
    check("t5_m0_busy",     64'(busy),    64'd0);
    step();
    check("t5_m0_done_end", 64'(done),     64'd0);
    check("t5_m0_nowrite",  64'(n_writes), 64'(nw0));
    dc0 = done_count;
    start_job(4'd2, 4'd1, 8'h40);
    psum_valid = 5'b00001;
    psum_data  = 80'(16'h0001);
    exp_q.push_back(mk(8'h40, 40'h0100000000));
    step();
    psum_valid = '0;
    start_job(4'd7, 4'd5, 8'h50);
    check("t5_still_busy", 64'(busy), 64'd1);
    psum_valid = 5'b00001;
    psum_data  = 80'(16'h0002);
    exp_q.push_back(mk(8'h41, 40'h0200000000));
    step();
    psum_valid = '0;
    repeat (5) step();
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t5_done_count",    64'(done_count),   64'(dc0 + 1));

    // 6: reset in the middle of a 5-row job
    dc0 = done_count;
    start_job(4'd5, 4'd1, 8'h60);
    psum_valid = 5'b00001;
    psum_data  = 80'(16'h0011);
    exp_q.push_back(mk(8'h60, 40'h1100000000));
    step();
    psum_data = 80'(16'h0022);
    exp_q.push_back(mk(8'h61, 40'h2200000000));
    step();
    psum_valid = '0;
    step(); step();
    rst        = 1'b0;
    psum_valid = 5'b00001;
    psum_data  = 80'(16'h0033);
    step();
    rst        = 1'b1;
    psum_valid = '0;
    check("t6_rst_wen",   64'(gbuf_wen),   64'd0);
    check("t6_rst_waddr", 64'(gbuf_waddr), 64'd0);
    check("t6_rst_wdata", 64'(gbuf_wdata), 64'd0);
    check("t6_rst_busy",  64'(busy),       64'd0);
    repeat (6) step();
    check("t6_no_done", 64'(done_count), 64'(dc0));
    start_job(4'd2, 4'd2, 8'h60);
    psum_valid = 5'b00011;
    psum_data  = {48'h0, 16'h0300, 16'h0044};
    exp_q.push_back(mk(8'h60, 40'h44FF000000));
    step();
    psum_data = {48'h0, 16'h0006, 16'h0005};
    exp_q.push_back(mk(8'h61, 40'h0506000000));
    step();
    psum_valid = '0;
    repeat (5) step();
    check("t6_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t6_done_count",    64'(done_count),   64'(dc0 + 1));

    // 7: n clamps to ARRAY_SIZE and the address wraps past 0xFF
    dc0 = done_count;
    start_job(4'd2, 4'd7, 8'hFF);
    psum_valid = 5'b11111;
    psum_data  = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    exp_q.push_back(mk(8'hFF, 40'h0102030405));
    step();
    psum_data = {5{16'h00FE}};
    exp_q.push_back(mk(8'h00, 40'hFEFEFEFEFE));
    step();
    psum_valid = '0;
    repeat (5) step();
    check("t7_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t7_done_count",    64'(done_count),   64'(dc0 + 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
